// File: rtl/instr_fetch.sv
// Fetch stage for a LEGv8-style pipeline: owns the PC, addresses a combinational
// instruction ROM, and registers the returned word into the IF/ID stage.
module instr_fetch #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int          MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        br_uncond,
  input  logic [25:0] br_imm26,
  input  logic [18:0] br_imm19,
  input  logic [63:0] br_pc,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_instr,
  output logic [63:0] ifid_pc,
  output logic        ifid_valid,
  output logic        fetch_err,
  output logic [31:0] fetch_count
);

  // Highest byte address at which a whole 32-bit word still fits in memory.
  localparam logic [63:0] LAST_WORD_ADDR = 64'(MEM_BYTES - 4);

  logic [63:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [63:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [63:0] br_offset;
  logic [63:0] br_target;
  logic        pc_legal;

  // Word offsets become byte offsets: sign-extend, then shift left by two.
  always_comb begin
    if (br_uncond) begin
      br_offset = {{36{br_imm26[25]}}, br_imm26, 2'b00};
    end else begin
      br_offset = {{43{br_imm19[18]}}, br_imm19, 2'b00};
    end
    br_target = br_pc + br_offset;
  end

  // Comparing against the last word address avoids the overflow of PC+3.
  always_comb begin
    pc_legal = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_WORD_ADDR);
  end

  always_comb begin
    pc_d          = pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_err_d   = fetch_err_q;
    fetch_count_d = fetch_count_q;

    if (br_taken) begin
      pc_d         = br_target;
      ifid_instr_d = 32'd0;
      ifid_pc_d    = 64'd0;
      ifid_valid_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pc_legal) begin
      ifid_instr_d  = imem_instr;
      ifid_pc_d     = pc_q;
      ifid_valid_d  = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
      pc_d          = pc_q + 64'd4;
    end else begin
      // Parked on a bad address: only a redirect or reset moves the PC.
      fetch_err_d  = 1'b1;
      ifid_valid_d = 1'b0;
      ifid_instr_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      ifid_instr_q  <= 32'd0;
      ifid_pc_q     <= 64'd0;
      ifid_valid_q  <= 1'b0;
      fetch_err_q   <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_err_q   <= fetch_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_valid  = ifid_valid_q;
  assign fetch_err   = fetch_err_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run compared
// against a behavioural model of the fetch rules.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic        br_uncond;
  logic [25:0] br_imm26;
  logic [18:0] br_imm19;
  logic [63:0] br_pc;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;
  logic        ifid_valid;
  logic        fetch_err;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [256];

  // Behavioural model state
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [63:0] m_ipc;
  logic        m_valid;
  logic        m_err;
  logic [31:0] m_count;

  instr_fetch #(.RESET_PC(64'd0), .MEM_BYTES(1024)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_uncond(br_uncond), .br_imm26(br_imm26), .br_imm19(br_imm19),
    .br_pc(br_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
    .fetch_err(fetch_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr < 64'd1024) imem_instr = rom[imem_addr[9:2]];
    else imem_instr = 32'hDEAD_BEEF;
  end

  function automatic logic [31:0] rom_word(input logic [63:0] a);
    if (a < 64'd1024) return rom[a[9:2]];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic model_step();
    longint off;
    if (reset) begin
      m_pc = 64'd0; m_instr = 0; m_ipc = 0; m_valid = 0; m_err = 0; m_count = 0;
    end else if (br_taken) begin
      off = br_uncond ? longint'($signed(br_imm26)) : longint'($signed(br_imm19));
      m_pc = br_pc + 64'(off * 4);
      m_instr = 0; m_ipc = 0; m_valid = 0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if ((m_pc % 4 == 0) && (m_pc <= 64'd1020)) begin
      m_instr = rom_word(m_pc); m_ipc = m_pc; m_valid = 1;
      m_count = m_count + 1; m_pc = m_pc + 4;
    end else begin
      m_err = 1; m_valid = 0; m_instr = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    reset = 0; stall = 0; br_taken = 0; br_uncond = 0;
    br_imm26 = 0; br_imm19 = 0; br_pc = 0;
  endtask

  task automatic do_branch(input logic unc, input logic [63:0] pc, input int imm);
    br_taken = 1; br_uncond = unc; br_pc = pc;
    br_imm26 = 26'(imm); br_imm19 = 19'(imm);
    cycle();
    br_taken = 0;
  endtask

  task automatic do_reset();
    reset = 1; cycle(); reset = 0;
  endtask

  task automatic test_reset();
    idle(); reset = 1; br_taken = 1; br_pc = 64'h40; stall = 1;
    cycle(); idle();
    checks++; if (imem_addr !== 64'd0) begin errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 64'd0); end
    checks++; if (ifid_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got=%h exp=0", ifid_instr); end
    checks++; if (ifid_pc !== 64'd0) begin errors++; $display("FAIL reset_ifid_pc got=%h exp=0", ifid_pc); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", fetch_err); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    idle(); do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_addr !== 64'(4 * i)) begin errors++; $display("FAIL seq_addr i=%0d got=%0d exp=%0d", i, imem_addr, 4 * i); end
      cycle();
      checks++; if (ifid_instr !== 32'(100 + i) || ifid_pc !== 64'(4 * i) || ifid_valid !== 1'b1)
        begin errors++; $display("FAIL seq_capture i=%0d got=%0d/%0d/%b exp=%0d/%0d/1", i, ifid_instr, ifid_pc, ifid_valid, 100 + i, 4 * i); end
    end
    checks++; if (imem_addr !== 64'd12 || fetch_count !== 32'd3)
      begin errors++; $display("FAIL seq_end got addr=%0d count=%0d exp addr=12 count=3", imem_addr, fetch_count); end
    $display("test_sequential done");
  endtask

  task automatic test_stall();
    idle(); do_reset(); cycle(); cycle();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++; if (imem_addr !== 64'd8 || ifid_instr !== 32'd101 || ifid_pc !== 64'd4 || fetch_count !== 32'd2)
        begin errors++; $display("FAIL stall_hold i=%0d got addr=%0d instr=%0d pc=%0d cnt=%0d exp 8/101/4/2", i, imem_addr, ifid_instr, ifid_pc, fetch_count); end
    end
    stall = 0; cycle();
    checks++; if (ifid_instr !== 32'd102 || ifid_pc !== 64'd8 || fetch_count !== 32'd3)
      begin errors++; $display("FAIL stall_release got instr=%0d pc=%0d cnt=%0d exp 102/8/3", ifid_instr, ifid_pc, fetch_count); end
    $display("test_stall done");
  endtask

  task automatic test_branch();
    do_branch(1'b0, 64'd8, -2);
    checks++; if (imem_addr !== 64'd0 || ifid_valid !== 1'b0 || ifid_instr !== 32'd0 || ifid_pc !== 64'd0 || fetch_count !== 32'd3)
      begin errors++; $display("FAIL br_flush got addr=%0d v=%b instr=%h pc=%0d cnt=%0d exp 0/0/0/0/3", imem_addr, ifid_valid, ifid_instr, ifid_pc, fetch_count); end
    cycle();
    checks++; if (ifid_instr !== 32'd100 || ifid_pc !== 64'd0 || ifid_valid !== 1'b1)
      begin errors++; $display("FAIL br_resume got instr=%0d pc=%0d v=%b exp 100/0/1", ifid_instr, ifid_pc, ifid_valid); end
    do_branch(1'b1, 64'd0, 5);
    checks++; if (imem_addr !== 64'd20) begin errors++; $display("FAIL br_uncond got=%0d exp=20", imem_addr); end
    stall = 1; do_branch(1'b0, 64'd20, 1); stall = 0;
    checks++; if (imem_addr !== 64'd24 || ifid_valid !== 1'b0)
      begin errors++; $display("FAIL br_over_stall got addr=%0d v=%b exp 24/0", imem_addr, ifid_valid); end
    do_branch(1'b1, 64'd4, -2);
    checks++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
      begin errors++; $display("FAIL br_wrap got=%h exp=fffffffffffffffc", imem_addr); end
    $display("test_branch done");
  endtask

  task automatic test_range_end();
    idle(); do_reset();
    do_branch(1'b1, 64'd1020, 0);
    cycle();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'd1020 || ifid_instr !== 32'h1234_5678 || imem_addr !== 64'd1024)
      begin errors++; $display("FAIL range_last got v=%b pc=%0d instr=%h addr=%0d exp 1/1020/12345678/1024", ifid_valid, ifid_pc, ifid_instr, imem_addr); end
    cycle();
    checks++; if (fetch_err !== 1'b1 || ifid_valid !== 1'b0 || imem_addr !== 64'd1024 || fetch_count !== 32'd1)
      begin errors++; $display("FAIL range_err got err=%b v=%b addr=%0d cnt=%0d exp 1/0/1024/1", fetch_err, ifid_valid, imem_addr, fetch_count); end
    cycle();
    checks++; if (imem_addr !== 64'd1024 || ifid_instr !== 32'd0)
      begin errors++; $display("FAIL range_parked got addr=%0d instr=%h exp 1024/0", imem_addr, ifid_instr); end
    do_branch(1'b0, 64'd1024, -256);
    cycle();
    checks++; if (fetch_err !== 1'b1 || ifid_valid !== 1'b1 || ifid_instr !== 32'd100 || imem_addr !== 64'd4)
      begin errors++; $display("FAIL range_resume got err=%b v=%b instr=%0d addr=%0d exp 1/1/100/4", fetch_err, ifid_valid, ifid_instr, imem_addr); end
    $display("test_range_end done");
  endtask

  task automatic test_misaligned();
    idle(); do_reset();
    do_branch(1'b0, 64'd2, 0);
    checks++; if (imem_addr !== 64'd2 || fetch_err !== 1'b0)
      begin errors++; $display("FAIL mis_target got addr=%0d err=%b exp 2/0", imem_addr, fetch_err); end
    do_branch(1'b0, 64'd2, 0);
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL mis_branch_wins got err=%b exp 0", fetch_err); end
    cycle();
    checks++; if (fetch_err !== 1'b1 || ifid_valid !== 1'b0 || imem_addr !== 64'd2)
      begin errors++; $display("FAIL mis_err got err=%b v=%b addr=%0d exp 1/0/2", fetch_err, ifid_valid, imem_addr); end
    $display("test_misaligned done");
  endtask

  task automatic test_mid_reset();
    idle(); do_reset();
    do_branch(1'b0, 64'd2, 0); cycle();
    do_branch(1'b0, 64'd0, 0);
    for (int i = 0; i < 7; i++) cycle();
    checks++; if (fetch_count !== 32'd7 || imem_addr !== 64'd28 || fetch_err !== 1'b1)
      begin errors++; $display("FAIL midrst_pre got cnt=%0d addr=%0d err=%b exp 7/28/1", fetch_count, imem_addr, fetch_err); end
    reset = 1; stall = 1; cycle(); idle();
    checks++; if (imem_addr !== 64'd0 || ifid_instr !== 32'd0 || ifid_pc !== 64'd0 || ifid_valid !== 1'b0 || fetch_err !== 1'b0 || fetch_count !== 32'd0)
      begin errors++; $display("FAIL midrst_post got addr=%0d instr=%h pc=%0d v=%b err=%b cnt=%0d exp all 0", imem_addr, ifid_instr, ifid_pc, ifid_valid, fetch_err, fetch_count); end
    $display("test_mid_reset done");
  endtask

  task automatic test_random();
    int imm;
    logic [63:0] t;
    idle(); do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) < 2);
      stall = ($urandom_range(0, 99) < 20);
      br_taken = ($urandom_range(0, 99) < 15);
      br_uncond = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0, 1, 2: t = 64'(4 * $urandom_range(0, 255));
        3:       t = $urandom_range(0, 1) ? 64'd1016 : 64'd1020;
        4:       t = 64'($urandom_range(0, 1023));
        default: t = {$urandom, $urandom};
      endcase
      imm = int'($urandom_range(0, 200)) - 100;
      br_imm26 = 26'(imm); br_imm19 = 19'(imm);
      br_pc = t - 64'(longint'(imm) * 4);
      cycle();
      checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rand_addr c=%0d got=%h exp=%h", c, imem_addr, m_pc); end
      checks++; if (ifid_instr !== m_instr) begin errors++; $display("FAIL rand_instr c=%0d got=%h exp=%h", c, ifid_instr, m_instr); end
      checks++; if (ifid_pc !== m_ipc) begin errors++; $display("FAIL rand_ifid_pc c=%0d got=%h exp=%h", c, ifid_pc, m_ipc); end
      checks++; if (ifid_valid !== m_valid) begin errors++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, ifid_valid, m_valid); end
      checks++; if (fetch_err !== m_err) begin errors++; $display("FAIL rand_err c=%0d got=%b exp=%b", c, fetch_err, m_err); end
      checks++; if (fetch_count !== m_count) begin errors++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, fetch_count, m_count); end
    end
    idle();
    $display("test_random done");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = (i < 64) ? 32'(i + 100) : $urandom;
    rom[255] = 32'h1234_5678;
    m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_err = 0; m_count = 0;
    idle();
    #2;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_range_end();
    test_misaligned();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
